// File: rtl/utmi_rx_sm.sv
// UTMI receive packet state machine: SYNC/PID detection, single-entry payload holding register, EOP termination.
// Optional CRC16 payload check is built when RX_CRC16_EN is defined.
module utmi_rx_sm #(
  parameter logic [7:0] SYNC_BYTE = 8'b0010_1010,
  parameter logic [7:0] EOP_BYTE  = 8'b0001_0000,
  parameter int         MAX_BYTES = 64,
  parameter int         CNT_W     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_valid,
  input  logic       rx_bit_err,
  input  logic       RD_ACK,
  output logic [7:0] DataOut,
  output logic       RX_VALID,
  output logic       RX_ACTIVE,
  output logic [3:0] PID_OUT,
  output logic       PID_VALID,
  output logic       RX_ERROR,
  output logic [1:0] ERR_CODE,
  output logic [2:0] state_dbg
);

  // Holding register handshake: DataOut is valid while RX_VALID=1; RD_ACK=1 in such a
  // cycle consumes it on that edge, and a new byte on the same edge refills it.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PID_S = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] byte_cnt;
  logic             load, pid_ok, enter_err;
  logic [1:0]       err_code_n;
  logic             crc_ok;

`ifdef RX_CRC16_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'hA001 : 16'h0000);
    end
    return r;
  endfunction

  // Residue of a packet whose trailing CRC bytes are correct.
  assign crc_ok = (crc == 16'hB001);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc <= 16'hFFFF;
    end else if (pid_ok) begin
      crc <= 16'hFFFF;
    end else if (load) begin
      crc <= crc16_byte(crc, rx_byte);
    end
  end
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    pid_ok     = 1'b0;
    enter_err  = 1'b0;
    err_code_n = ERR_CODE;
    case (state)
      IDLE: begin
        if (rx_byte_valid && rx_byte == SYNC_BYTE) state_n = PID_S;
      end
      PID_S: begin
        if (rx_bit_err) begin
          state_n = ERROR; enter_err = 1'b1; err_code_n = 2'b11;
        end else if (rx_byte_valid) begin
          if (rx_byte[7:4] == ~rx_byte[3:0]) begin
            pid_ok  = 1'b1;
            state_n = DATA;
          end else begin
            state_n = ERROR; enter_err = 1'b1; err_code_n = 2'b01;
          end
        end
      end
      DATA: begin
        if (rx_bit_err) begin
          state_n = ERROR; enter_err = 1'b1; err_code_n = 2'b11;
        end else if (rx_byte_valid) begin
          if (rx_byte == EOP_BYTE) begin
            // A CRC failure skips the EOP wait: DONE returns to IDLE next cycle.
            state_n = DONE;
            if (!crc_ok) begin
              enter_err = 1'b1; err_code_n = 2'b00;
            end
          end else if (byte_cnt == CNT_W'(MAX_BYTES) || (RX_VALID && !RD_ACK)) begin
            state_n = ERROR; enter_err = 1'b1; err_code_n = 2'b10;
          end else begin
            load = 1'b1;
          end
        end
      end
      DONE:  state_n = IDLE;
      ERROR: begin
        if (rx_byte_valid && rx_byte == EOP_BYTE) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      DataOut   <= 8'h00;
      RX_VALID  <= 1'b0;
      RX_ACTIVE <= 1'b0;
      PID_OUT   <= 4'h0;
      PID_VALID <= 1'b0;
      RX_ERROR  <= 1'b0;
      ERR_CODE  <= 2'b00;
    end else begin
      state     <= state_n;
      RX_ACTIVE <= (state_n == PID_S) || (state_n == DATA);
      PID_VALID <= pid_ok;
      RX_ERROR  <= enter_err;
      ERR_CODE  <= err_code_n;
      if (pid_ok) PID_OUT <= rx_byte[7:4];
      if (pid_ok) begin
        byte_cnt <= '0;
      end else if (load) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (load) DataOut <= rx_byte;
      RX_VALID <= load | (RX_VALID & ~RD_ACK);
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/utmi_rx_sm.md
Name: utmi_rx_sm

Overview:
- Receive-side packet state machine for the UTMI byte interface; the counterpart of the transmit state machine.
- Consumes decoded bytes from the NRZI/bit-unstuff stage and detects the SYNC and PID bytes, then forwards payload bytes through a single-entry holding register to the link layer.
- Terminates each packet on the EOP byte.
- Flags PID, length, overflow and bit-stuff errors.

Parameters:
- SYNC_BYTE, 8'b00101010, byte value that opens a packet.
- EOP_BYTE, 8'b00010000, byte value that closes a packet.
- MAX_BYTES, 64, maximum payload bytes per packet, excluding SYNC, PID and EOP.
- CNT_W, 7, byte counter width; must satisfy 2^CNT_W > MAX_BYTES.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rx_byte  in  8  decoded byte from the line decoder.
- rx_byte_valid  in  1  one-cycle strobe; rx_byte is valid this cycle.
- rx_bit_err  in  1  bit-stuff error strobe from the decoder.
- RD_ACK  in  1  link layer consumes the holding register this cycle.
- DataOut  out  8  payload byte in the holding register.
- RX_VALID  out  1  holding register full; DataOut is valid.
- RX_ACTIVE  out  1  a packet is in progress.
- PID_OUT  out  4  upper nibble of the accepted PID.
- PID_VALID  out  1  one-cycle pulse when PID_OUT updates.
- RX_ERROR  out  1  one-cycle error pulse.
- ERR_CODE  out  2  error cause, held until the next error: 00 CRC, 01 PID, 10 overflow/length, 11 bit-stuff.

Behaviour:
- Reset (reset=0): state returns to IDLE asynchronously. All outputs go to 0: DataOut=0, RX_VALID=0, RX_ACTIVE=0, PID_OUT=0, PID_VALID=0, RX_ERROR=0, ERR_CODE=0. Byte counter and holding register clear. Reset mid-packet discards the packet and does not raise RX_ERROR.
- Bytes are acted on only in cycles where rx_byte_valid=1. All outputs are registered.
- IDLE:
  - rx_byte==SYNC_BYTE → PID_S; RX_ACTIVE=1 from the next cycle.
  - Any other byte is ignored.
  - rx_bit_err is ignored.
- PID_S:
  - If rx_byte[7:4]==~rx_byte[3:0]: PID_OUT<=rx_byte[7:4], PID_VALID pulses, counter<=0, → DATA.
  - Otherwise → ERROR with ERR_CODE=01.
- DATA:
  - rx_byte==EOP_BYTE → DONE.
  - Any other byte: load it into the holding register, set RX_VALID=1 and increment the counter. Latency is 1 cycle from the strobe to RX_VALID/DataOut.
  - A non-EOP byte arriving when counter==MAX_BYTES → ERROR with ERR_CODE=10; the byte is not loaded.
- Holding register:
  - RD_ACK while RX_VALID=1 clears RX_VALID on the next edge.
  - A new byte in the same cycle as RD_ACK loads the new byte; RX_VALID stays 1.
  - A new byte while RX_VALID=1 and RD_ACK=0 is an overflow: → ERROR with ERR_CODE=10; the old byte is kept.
  - RD_ACK while RX_VALID=0 has no effect.
  - The holding register is independent of the packet state: a byte left in it survives DONE and ERROR until acknowledged.
- DONE: RX_ACTIVE=0; after one cycle → IDLE.
- ERROR:
  - RX_ERROR pulses for 1 cycle on entry; ERR_CODE is updated in the same cycle; RX_ACTIVE=0.
  - Bytes are discarded until EOP_BYTE arrives, then → IDLE.
  - SYNC_BYTE seen in ERROR does not restart the packet.
- rx_bit_err in PID_S or DATA → ERROR with ERR_CODE=11. If rx_bit_err and rx_byte_valid occur in the same cycle, the error wins and the byte is dropped.
- EOP_BYTE in PID_S is a PID error (ERR_CODE=01). A packet with zero payload bytes is legal.

Optional Feature:
- Macro: RX_CRC16_EN.
- Defined:
  - A CRC16 (poly 0xA001 reflected, init 0xFFFF, LSB-first) runs over every DATA byte, including the two trailing CRC bytes.
  - On EOP the register must equal 16'hB001. If it does → DONE; otherwise → ERROR with ERR_CODE=00 and no further EOP wait (→ IDLE next cycle).
  - The CRC register is reset on PID acceptance.
  - CRC bytes are still forwarded on DataOut.
- Undefined: no CRC logic is built; ERR_CODE=00 is never produced by the CRC.

Test Plan:
- Good packet: bytes 2A,78,68,65,6C,10 with RD_ACK each cycle → PID_VALID with PID_OUT=7; DataOut 68,65,6C each with RX_VALID; RX_ACTIVE falls after 10; no RX_ERROR.
- Bad PID: 2A,77 → RX_ERROR pulse, ERR_CODE=01; further bytes ignored until 10; then 2A,78 is accepted normally.
- Overflow: 2A,78,11,22 with RD_ACK held 0 → DataOut stays 11; RX_ERROR with ERR_CODE=10; RX_VALID stays 1 until RD_ACK.
- Length limit: MAX_BYTES=4, send 2A,78 then 5 payload bytes → 4 bytes forwarded; 5th byte raises ERR_CODE=10.
- Bit-stuff error mid-DATA plus async reset: rx_bit_err after 2 payload bytes → ERR_CODE=11. Then reset=0 mid-packet → all outputs 0 immediately, with no RX_ERROR pulse.
- RX_CRC16_EN: payload 01,02 followed by a correct CRC → no error. The same packet with a corrupted CRC byte → RX_ERROR with ERR_CODE=00.
